// File: rtl/mul_four_mc_if.sv
// mul_four_mc_if: custom-instruction port bundle for mul_four_mc.
//   clk_en : clock qualifier; when low the block holds all state
//   start  : one-cycle request, taken only when the block is idle
//   dataa  : IEEE-754 single-precision operand
//   done   : one-cycle completion pulse; result valid in the same cycle
//   result : scaled IEEE-754 single; held until the next done
// master = processor side, slave = the instruction block.
interface mul_four_mc_if;
  logic        clk_en;
  logic        start;
  logic [31:0] dataa;
  logic        done;
  logic [31:0] result;

  modport master (output clk_en, start, dataa, input done, result);
  modport slave  (input clk_en, start, dataa, output done, result);
endinterface

// File: rtl/mul_four_mc.sv
// mul_four_mc: multi-cycle custom instruction computing the exact
// IEEE-754 single-precision product dataa * 2^SHIFT.
// One doubling step is applied per enabled cycle. Subnormals are
// normalised one bit per step. Overflow saturates to signed infinity.
// Inf and NaN pass through unchanged.
//   clk   : system clock
//   reset : synchronous, active-high reset
//   bus   : mul_four_mc_if.slave (clk_en, start, dataa, done, result)
// Parameter SHIFT : log2 of the scale factor, legal range 1..8.
// Optional macro FTZ_EN : flush subnormal operands to signed zero at capture.
//
// state | meaning
// IDLE  | waiting for start
// SCALE | one doubling step per enabled edge, count steps remaining
// DONE  | done pulse, result valid
module mul_four_mc #(
  parameter int SHIFT = 2
) (
  input logic          clk,
  input logic          reset,
  mul_four_mc_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SCALE, DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  count;
  logic        s;
  logic [7:0]  e, e_nx;
  logic [22:0] m, m_nx;
  logic [31:0] result_q;
  logic [23:0] m_shl;

  // One doubling step applied to the working value {s, e, m}.
  always_comb begin
    e_nx  = e;
    m_nx  = m;
    m_shl = {m, 1'b0};
    if (e == 8'd255) begin
      e_nx = e;
      m_nx = m;
    end else if (e == 8'd0) begin
      // Zero stays zero. A subnormal shifts left; a carry into the
      // hidden-bit position turns it into the smallest normal exponent.
      m_nx = m_shl[22:0];
      if (m_shl[23]) e_nx = 8'd1;
    end else if (e <= 8'd253) begin
      e_nx = e + 8'd1;
    end else begin
      e_nx = 8'd255;
      m_nx = 23'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      count    <= 4'd0;
      s        <= 1'b0;
      e        <= 8'd0;
      m        <= 23'd0;
      result_q <= 32'h0;
    end else if (bus.clk_en) begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (bus.start) begin
            s     <= bus.dataa[31];
            e     <= bus.dataa[30:23];
            count <= 4'(SHIFT);
`ifdef FTZ_EN
            if (bus.dataa[30:23] == 8'd0) m <= 23'd0;
            else                          m <= bus.dataa[22:0];
`else
            m <= bus.dataa[22:0];
`endif
          end
        end
        SCALE: begin
          e     <= e_nx;
          m     <= m_nx;
          count <= count - 4'd1;
          // The last step lands directly in the result register.
          if (count == 4'd1) result_q <= {s, e_nx, m_nx};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SCALE;
      SCALE:   if (count == 4'd1) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.done   = (state == DONE);
    bus.result = result_q;
  end

endmodule

// File: tb/tb_mul_four_mc.sv
module tb_mul_four_mc;
  localparam int SHIFT = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mul_four_mc_if bus();

  mul_four_mc #(.SHIFT(SHIFT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  logic prev_done  = 1'b0;

`ifdef FTZ_EN
  localparam logic [31:0] EXP_SUB1 = 32'h00000000;
  localparam logic [31:0] EXP_SUB2 = 32'h00000000;
  localparam logic [31:0] EXP_SUB3 = 32'h00000000;
  localparam logic [31:0] EXP_SUB4 = 32'h80000000;
`else
  localparam logic [31:0] EXP_SUB1 = 32'h00000004;
  localparam logic [31:0] EXP_SUB2 = 32'h01400000;
  localparam logic [31:0] EXP_SUB3 = 32'h01000000;
  localparam logic [31:0] EXP_SUB4 = 32'h80000004;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever done is presented.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      chk("done_pulse_width", {31'b0, prev_done}, 32'd0);
      if (sbq.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_done: got done=1 result=%08h expected no done", bus.result);
      end else begin
        mon_e = sbq.pop_front();
        chk("result", bus.result, mon_e.res);
        chk("latency_cycle", cyc, mon_e.cyc);
      end
    end
    prev_done = bus.done;
  end

  task automatic wait_idle();
    int n = 0;
    while (sbq.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", n);
      sbq.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run_op(input logic [31:0] d, input logic [31:0] exp,
                        input bit stall, input bit busy_start);
    int   c0;
    exp_t x;
    @(negedge clk);
    bus.dataa  = d;
    bus.start  = 1'b1;
    bus.clk_en = 1'b1;
    @(posedge clk);
    #1;
    c0        = cyc;
    bus.start = 1'b0;
    x.res     = exp;
    x.cyc     = c0 + SHIFT + (stall ? 2 : 0);
    sbq.push_back(x);
    if (stall) begin
      @(negedge clk) bus.clk_en = 1'b1;
      @(negedge clk) bus.clk_en = 1'b0;
      @(negedge clk) bus.clk_en = 1'b0;
      @(negedge clk) bus.clk_en = 1'b1;
    end
    if (busy_start) begin
      @(negedge clk);
      bus.start = 1'b1;
      bus.dataa = 32'h3F800000;
      @(negedge clk);
      bus.start = 1'b0;
    end
    wait_idle();
    chk("result_hold", bus.result, exp);
  endtask

  initial begin
    reset      = 1'b1;
    bus.clk_en = 1'b1;
    bus.start  = 1'b0;
    bus.dataa  = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset_done", {31'b0, bus.done}, 32'd0);
    chk("reset_result", bus.result, 32'h0);
    reset = 1'b0;

    run_op(32'h3FC00000, 32'h40C00000, 0, 0);  // 1.5 -> 6.0
    run_op(32'hC0400000, 32'hC1400000, 0, 0);  // -3.0 -> -12.0
    run_op(32'h80000000, 32'h80000000, 0, 0);  // -0
    run_op(32'h7F7FFFFF, 32'h7F800000, 0, 0);  // max normal -> +Inf
    run_op(32'h7F000000, 32'h7F800000, 0, 0);  // e=254 -> +Inf
    run_op(32'h7E800000, 32'h7F800000, 0, 0);  // e=253 -> 254 -> Inf
    run_op(32'h7FC00001, 32'h7FC00001, 0, 0);  // NaN payload kept
    run_op(32'hFF800000, 32'hFF800000, 0, 0);  // -Inf
    run_op(32'h00000001, EXP_SUB1, 0, 0);
    run_op(32'h00600000, EXP_SUB2, 0, 0);
    run_op(32'h00400000, EXP_SUB3, 0, 0);
    run_op(32'h80000001, EXP_SUB4, 0, 0);

    run_op(32'h3FC00000, 32'h40C00000, 1, 0);  // clk_en 1,0,0,1,1
    run_op(32'hC0400000, 32'hC1400000, 0, 1);  // start while busy

    // Reset while in SCALE: no done, result cleared.
    @(negedge clk);
    bus.dataa = 32'h3FC00000;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("reset_abort_result", bus.result, 32'h0);
    chk("reset_abort_done", {31'b0, bus.done}, 32'd0);

    run_op(32'h3FC00000, 32'h40C00000, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
